fetch_queue_stage: RTL and testbench
====================================

Name: fetch_queue_stage

Overview:
Parametrised successor to the fetch stage and IF/ID register pair. It combines the PC generator with a DEPTH-entry instruction queue, decoupling fetch from decode. Decode consumes through a valid/ready handshake, and a redirect port flushes the queue and reloads the PC. It sits between the instruction memory and the decode stage.

Parameters:
XLEN, 32, PC and instruction width in bits.
DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
RESET_PC, 0, PC value after reset.
PC_STEP, 4, PC increment per fetched instruction.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous reset, active-high.
fetch_en  input  1  fetch enable; low holds the PC and blocks pushes (PCWrite successor).
redirect_valid  input  1  flush the queue and load the PC from redirect_pc (IF_flush successor).
redirect_pc  input  XLEN  new PC on redirect, taken as-is with no alignment.
imem_addr  output  XLEN  fetch address; always equals the PC register.
imem_rdata  input  XLEN  instruction at imem_addr, valid in the same cycle (combinational memory).
id_valid  output  1  head entry is valid; equals !q_empty.
id_ready  input  1  decode accepts the head entry (IFIDWrite successor).
id_pc  output  XLEN  PC of the head entry.
id_inst  output  XLEN  instruction of the head entry.
id_pc_next  output  XLEN  id_pc + PC_STEP, modulo 2^XLEN.
q_count  output  $clog2(DEPTH)+1  number of occupied entries.
q_full  output  1  q_count == DEPTH.
q_empty  output  1  q_count == 0.

Behaviour:
- Reset (async, immediate):
  - PC = RESET_PC, so imem_addr = RESET_PC.
  - Read/write pointers and q_count = 0; q_empty = 1; q_full = 0; id_valid = 0.
  - All storage entries = 0, so id_pc = 0, id_inst = 0 and id_pc_next = PC_STEP.
- Pop: occurs when id_valid && id_ready; the read pointer advances, wrapping modulo DEPTH.
- Push condition: fetch_en && !redirect_valid && (!q_full || pop).
  - On push, {PC, imem_rdata} is written at the write pointer, which wraps modulo DEPTH.
  - On push, PC <= PC + PC_STEP, wrapping modulo 2^XLEN.
- No push: PC holds.
- Simultaneous push and pop: q_count is unchanged. This is legal when full, so throughput stays one instruction per cycle.
- Latency: an instruction fetched in cycle N appears at id_* in cycle N+1 at the earliest (queue was empty). There is no combinational path from imem_rdata to id_*.
- Redirect (highest priority):
  - Next edge: pointers and q_count = 0, PC = redirect_pc, no push.
  - A pop in the same cycle still completes from decode's view; decode squashes it by its own flush.
  - Entries are not cleared on flush; id_valid = 0 masks them.
  - The cycle after redirect: imem_addr = redirect_pc, and that instruction reaches id_* one cycle later.
- Back-pressure: while id_valid && !id_ready, id_pc, id_inst and id_pc_next hold stable.
- Fill and hold: the queue fills to DEPTH, then q_full = 1 and the PC holds until a pop.
- fetch_en low: the PC and queue contents hold; pops still drain the queue.
- Reset asserted mid-operation overrides everything, including a pending redirect.
- id_pc_next is combinational from the head entry.

Optional Feature:
FETCHQ_STATS_EN.
- Defined: adds outputs stall_cycles (32 bits) and flush_count (16 bits), both reset to 0 and both wrapping on overflow.
  - stall_cycles increments each cycle where fetch_en && !redirect_valid && q_full && !pop.
  - flush_count increments on each cycle with redirect_valid = 1.
- Undefined: neither port nor their logic exists; all other behaviour is identical.

Test Plan:
1. Reset, then fetch_en = 1, id_ready = 1, imem_rdata = 0x00000013 -> id_valid rises in cycle 1 with id_pc = 0x0, then id_pc = 0x4, 0x8, one per cycle; id_pc_next = id_pc + 4.
2. fetch_en = 1, id_ready = 0 for 6 cycles (DEPTH = 4) -> q_count reaches 4, q_full = 1, imem_addr holds at 0x10, and id_pc holds at 0x0.
3. Full queue, then id_ready = 1 with fetch_en = 1 -> q_count stays 4 and one entry per cycle in PC order 0x0, 0x4, 0x8, 0xC, 0x10.
4. Queue holding 3 entries, redirect_valid = 1 with redirect_pc = 0x200 -> next cycle q_empty = 1 and imem_addr = 0x200; the cycle after, id_pc = 0x200.
5. rst pulsed mid-fill and asynchronous to clk -> outputs immediately show q_count = 0, id_valid = 0 and imem_addr = RESET_PC.
6. With FETCHQ_STATS_EN defined, hold full for 5 stalled cycles plus 2 redirects -> stall_cycles = 5 and flush_count = 2.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Fetch stage with PC generator and a DEPTH-entry instruction queue feeding decode.
// Optional FETCHQ_STATS_EN adds stall_cycles and flush_count counters.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [XLEN-1:0]          id_pc,
  output logic [XLEN-1:0]          id_inst,
  output logic [XLEN-1:0]          id_pc_next,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_full,
  output logic                     q_empty
`ifdef FETCHQ_STATS_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [15:0]              flush_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] r_pc;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_mem_pc   [DEPTH];
  logic [XLEN-1:0] r_mem_inst [DEPTH];

  logic w_pop;
  logic w_push;

  assign q_count    = r_count;
  assign q_full     = (r_count == CW'(DEPTH));
  assign q_empty    = (r_count == '0);
  assign id_valid   = !q_empty;
  assign imem_addr  = r_pc;
  assign id_pc      = r_mem_pc[r_rd_ptr];
  assign id_inst    = r_mem_inst[r_rd_ptr];
  assign id_pc_next = id_pc + XLEN'(PC_STEP);

  assign w_pop  = id_valid && id_ready;
  assign w_push = fetch_en && !redirect_valid && (!q_full || w_pop);

  // Redirect wins over push and pop; a same-cycle pop is squashed by decode itself.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_pc     <= redirect_pc;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + XLEN'(PC_STEP);
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is reset so the head outputs read as zero after reset; flush leaves it intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]   <= '0;
        r_mem_inst[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_pc;
      r_mem_inst[r_wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCHQ_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

  // A stall is a wanted fetch blocked only by a full queue that is not draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (fetch_en && !redirect_valid && q_full && !w_pop) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (redirect_valid) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage (DEPTH=4, RESET_PC=0, PC_STEP=4).
// Instruction memory model returns address + 0x13 so every entry is traceable.
module tb_fetch_queue_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetch_en;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc_next;
  logic [2:0]      q_count;
  logic            q_full;
  logic            q_empty;
`ifdef FETCHQ_STATS_EN
  logic [31:0]     stall_cycles;
  logic [15:0]     flush_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + 32'h13;

  fetch_queue_stage #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_pc_next(id_pc_next),
    .q_count(q_count), .q_full(q_full), .q_empty(q_empty)
`ifdef FETCHQ_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, ".valid"},   32'(id_valid), 32'd1);
    check({tag, ".pc"},      id_pc,         pc);
    check({tag, ".inst"},    id_inst,       pc + 32'h13);
    check({tag, ".pc_next"}, id_pc_next,    pc + 32'd4);
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; id_ready = 1'b0;
    #12;
    check("rst.addr",    imem_addr,          32'h0);
    check("rst.count",   32'(q_count),       32'd0);
    check("rst.empty",   32'(q_empty),       32'd1);
    check("rst.full",    32'(q_full),        32'd0);
    check("rst.valid",   32'(id_valid),      32'd0);
    check("rst.pc",      id_pc,              32'h0);
    check("rst.inst",    id_inst,            32'h0);
    check("rst.pc_next", id_pc_next,         32'h4);
    rst = 1'b0;

    // Streaming: one instruction per cycle, first visible one cycle after fetch.
    fetch_en = 1'b1; id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_head("stream", 32'(4 * k));
      check("stream.count", 32'(q_count), 32'd1);
      check("stream.addr",  imem_addr,    32'(4 * (k + 1)));
    end

    // Redirect back to 0 to restart from a clean queue.
    redirect_valid = 1'b1; redirect_pc = 32'h0; id_ready = 1'b0;
    tick();
    check("rd0.empty", 32'(q_empty), 32'd1);
    check("rd0.addr",  imem_addr,    32'h0);
    redirect_valid = 1'b0;

    // Fill and hold under back-pressure.
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("fill.count", 32'(q_count), 32'((k < DEPTH) ? k : DEPTH));
      check("fill.full",  32'(q_full),  32'((k >= DEPTH) ? 1 : 0));
      check("fill.addr",  imem_addr,    32'(4 * ((k < DEPTH) ? k : DEPTH)));
      check_head("fill", 32'h0);
    end

    // Full throughput: push and pop together keep the queue full; pointers wrap.
    id_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("thru.count", 32'(q_count), 32'd4);
      check_head("thru", 32'(4 * k));
      check("thru.addr", imem_addr, 32'(16 + 4 * k));
    end

    // fetch_en low: PC holds, pops still drain.
    fetch_en = 1'b0;
    tick();
    check("hold.count", 32'(q_count), 32'd3);
    check("hold.addr",  imem_addr,    32'h20);
    check_head("hold", 32'h14);

    // Redirect with 3 entries queued.
    fetch_en = 1'b1; id_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    check("redir.empty", 32'(q_empty),  32'd1);
    check("redir.valid", 32'(id_valid), 32'd0);
    check("redir.addr",  imem_addr,     32'h200);
    redirect_valid = 1'b0;
    tick();
    check_head("redir", 32'h200);
    check("redir.count", 32'(q_count), 32'd1);
    check("redir.addr2", imem_addr,    32'h204);

    // Asynchronous reset mid-fill, overriding a pending redirect.
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst.count", 32'(q_count),  32'd0);
    check("arst.valid", 32'(id_valid), 32'd0);
    check("arst.addr",  imem_addr,     32'h0);
    check("arst.pc",    id_pc,         32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    check("arst.redir_addr", imem_addr, 32'h0);
    rst = 1'b0;

    // PC wrap at the top of the address space.
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    check("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick();
    check("wrap.addr1",    imem_addr,  32'h0);
    check("wrap.pc",       id_pc,      32'hFFFF_FFFC);
    check("wrap.inst",     id_inst,    32'h0000_000F);
    check("wrap.pc_next",  id_pc_next, 32'h0);

`ifdef FETCHQ_STATS_EN
    rst = 1'b1;
    #1;
    check("stats.rst_stall", stall_cycles,       32'd0);
    check("stats.rst_flush", 32'(flush_count),   32'd0);
    rst = 1'b0; fetch_en = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0;
    repeat (4) tick();
    check("stats.full", 32'(q_full), 32'd1);
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    repeat (2) tick();
    redirect_valid = 1'b0;
    check("stats.stall", stall_cycles,     32'd5);
    check("stats.flush", 32'(flush_count), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
